// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit scheduler.
//                state_t    - scheduler state encoding (IDLE, LOAD, BUSY)
//                BIT_START  - bit slot index of the start bit
//                BIT_STOP   - bit slot index of the stop bit
//                BAUD_DIV_115200 - clk cycles per bit at 50 MHz / 115200 baud
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2
    } state_t;

    localparam logic [3:0] BIT_START       = 4'd0;
    localparam logic [3:0] BIT_STOP        = 4'd9;
    localparam int         BAUD_DIV_115200 = 434;

endpackage
`default_nettype wire

// File: rtl/uart_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_arb
//  Description : Requester arbiter for the shared UART serializer.
//                Default build: round-robin starting at an internal pointer
//                that moves to (grant+1) mod NUM_REQ whenever ptr_upd pulses.
//                With UART_TX_FIXED_PRIO_EN defined: fixed priority, lowest
//                index wins, no pointer state.
//  Ports       : clk, rst_n  - clock, async active-low reset (pointer only)
//                req         - per-requester pending flags
//                ptr_upd     - advance the pointer past the current winner
//                gnt         - one-hot winner (all zero when no request)
//                gnt_id      - winner index
//                any_req     - at least one requester pending
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr_upd,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any_req
);

    assign any_req = |req;

`ifdef UART_TX_FIXED_PRIO_EN
    // Descending scan so the last hit, i.e. the lowest index, wins.
    always_comb begin
        gnt_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_id = ID_W'(i);
            end
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n, ptr_upd};
`else
    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_hi_id;
    logic [ID_W-1:0] w_lo_id;
    logic            w_hi_found;

    // Two candidates: the lowest request at or above the pointer, and the
    // lowest request overall (used when the search has to wrap past the top).
    always_comb begin
        w_hi_id    = '0;
        w_lo_id    = '0;
        w_hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_id = ID_W'(i);
                if (ID_W'(i) >= r_ptr) begin
                    w_hi_id    = ID_W'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        gnt_id = w_hi_found ? w_hi_id : w_lo_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (ptr_upd) begin
            r_ptr <= (gnt_id == c_LAST_ID) ? '0 : gnt_id + ID_W'(1);
        end
    end
`endif

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = any_req && (gnt_id == ID_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Transmit controller sharing one UART serializer among
//                NUM_REQ byte requesters. Grants a requester in IDLE, issues
//                a one-cycle load (LOAD), then times the 10 bit slots of the
//                frame (BUSY) with a CLK_DIV clock divider.
//                Build option: UART_TX_FIXED_PRIO_EN selects fixed priority
//                (lowest index wins) instead of round-robin.
//  Ports       : clk, rst_n   - clock, async active-low reset
//                req_valid    - per-requester byte pending
//                req_data     - requester i byte in bits [8i+7:8i]
//                req_ready    - one-hot, one-cycle accept pulse
//                send_start   - one-cycle serializer load pulse
//                send_data    - byte presented with send_start
//                baud_busy    - frame in progress
//                baud_counte  - bit slot: 0 start, 1..8 data LSB first, 9 stop
//                grant_id     - index of the last granted requester
//                tx_done      - one-cycle pulse at the end of the stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CLK_DIV = 434,
    parameter int DIV_W   = $clog2(CLK_DIV),
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 send_start,
    output logic [7:0]           send_data,
    output logic                 baud_busy,
    output logic [3:0]           baud_counte,
    output logic [ID_W-1:0]      grant_id,
    output logic                 tx_done
);

    localparam logic [DIV_W-1:0] c_DIV_MAX = DIV_W'(CLK_DIV - 1);

    state_t             r_state,  w_state_nxt;
    logic [DIV_W-1:0]   r_div,    w_div_nxt;
    logic [NUM_REQ-1:0] r_ready,  w_ready_nxt;
    logic               r_start,  w_start_nxt;
    logic [7:0]         r_data,   w_data_nxt;
    logic               r_busy,   w_busy_nxt;
    logic [3:0]         r_cnt,    w_cnt_nxt;
    logic [ID_W-1:0]    r_gid,    w_gid_nxt;
    logic               r_done,   w_done_nxt;

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_any;
    logic               w_ptr_upd;

    uart_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .ptr_upd (w_ptr_upd),
        .gnt     (w_gnt),
        .gnt_id  (w_gnt_id),
        .any_req (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_ready <= '0;
            r_start <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= BIT_START;
            r_gid   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_ready <= w_ready_nxt;
            r_start <= w_start_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= w_busy_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gid   <= w_gid_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Outputs are registered, so the values computed here for the next state
    // are what appear on the ports while that state is current.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_ready_nxt = '0;
        w_start_nxt = 1'b0;
        w_data_nxt  = r_data;
        w_busy_nxt  = r_busy;
        w_cnt_nxt   = r_cnt;
        w_gid_nxt   = r_gid;
        w_done_nxt  = 1'b0;
        w_ptr_upd   = 1'b0;

        case (r_state)
            IDLE: begin
                w_busy_nxt = 1'b0;
                w_cnt_nxt  = BIT_START;
                w_div_nxt  = '0;
                if (w_any) begin
                    w_state_nxt = LOAD;
                    w_gid_nxt   = w_gnt_id;
                    w_ready_nxt = w_gnt;
                    w_start_nxt = 1'b1;
                    w_ptr_upd   = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_gnt[i]) begin
                            w_data_nxt = req_data[8*i +: 8];
                        end
                    end
                end
            end

            LOAD: begin
                w_state_nxt = BUSY;
                w_busy_nxt  = 1'b1;
                w_cnt_nxt   = BIT_START;
                w_div_nxt   = '0;
            end

            BUSY: begin
                if (r_div == c_DIV_MAX) begin
                    w_div_nxt = '0;
                    if (r_cnt == BIT_STOP) begin
                        w_state_nxt = IDLE;
                        w_busy_nxt  = 1'b0;
                        w_cnt_nxt   = BIT_START;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign req_ready   = r_ready;
    assign send_start  = r_start;
    assign send_data   = r_data;
    assign baud_busy   = r_busy;
    assign baud_counte = r_cnt;
    assign grant_id    = r_gid;
    assign tx_done     = r_done;

endmodule
`default_nettype wire
